shift_exec_pipe: RTL
====================

Name: shift_exec_pipe

Overview:
- Two-stage pipelined execute-stage shift unit between the ID/EX operand path and the EX/MEM register.
- Stage 1 latches operand, amount, mode and destination tag. Stage 2 computes SLL, SRA or ROR and registers the result.
- Valid/ready handshake on both sides; synchronous flush for branch mispredict.
- The combinational shift datapath is part of this block.

Parameters:
- DATA_W, 16, operand/result width.
- SHAMT_W, 4, shift-amount width; must equal log2(DATA_W).
- TAG_W, 4, destination-register tag width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- In_Valid  input  1  upstream offers an operation.
- In_Ready  output  1  block accepts the operation this cycle.
- Shift_In  input  DATA_W  operand.
- Shift_Val  input  SHAMT_W  shift amount, unsigned.
- Shift_Mode  input  2  00=SLL, 01=SRA, 10=ROR, 11=pass-through.
- In_Dst  input  TAG_W  destination tag.
- Flush  input  1  discard all in-flight operations.
- Out_Valid  output  1  result available.
- Out_Ready  input  1  downstream accepts the result.
- Shift_Out  output  DATA_W  result.
- Out_Dst  output  TAG_W  tag carried with the result.
- Flag_Z  output  1  result == 0 (optional feature).
- Flag_N  output  1  result MSB (optional feature).

Behaviour:
- Reset (async, rst_n=0): s1_valid, s2_valid, Out_Valid = 0. Shift_Out, Out_Dst, Flag_Z, Flag_N and all stage-1 data registers = 0.
- Transfer rules:
  - Input transfer occurs when In_Valid && In_Ready.
  - Output transfer occurs when Out_Valid && Out_Ready.
- Advance rules:
  - s2_adv = !s2_valid || Out_Ready.
  - s1_adv = s1_valid && s2_adv.
  - In_Ready = !s1_valid || s2_adv. This is combinational; full throughput of 1 op/cycle when Out_Ready is held 1.
- Latency: exactly 2 cycles from input transfer to Out_Valid when no stall.
- Stall holding: while Out_Valid && !Out_Ready, Shift_Out, Out_Dst and the flags hold stable. Stage 1 keeps its data, and In_Ready = !s1_valid.
- Arithmetic (computed from stage-1 registers, registered into stage 2):
  - SLL: zero fill.
  - SRA: sign fill from bit DATA_W-1.
  - ROR: rotate right by Shift_Val.
  - Pass-through: result = operand.
  - Shift_Val = 0 returns the operand unchanged for every mode.
  - Shift_Val = 15 SLL leaves only bit0 moved to bit15.
- Flush:
  - Synchronous; on the edge where Flush=1, s1_valid and s2_valid are cleared.
  - Any input transfer in that same cycle is discarded.
  - Out_Valid is 0 the following cycle.
  - An output transfer in the same cycle still counts as completed.
  - Flush has priority over all advance rules.
- Simultaneous events:
  - Stage 2 accepts from stage 1 in the same cycle it retires to downstream.
  - Stage 1 refills from input in the same cycle it hands off to stage 2.
- Data registers load only on their stage's advance/accept; they do not clear on flush (valid bits gate them).
- Reset mid-operation: all in-flight operations are lost; no output transfer completes after rst_n falls.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- Defined: Flag_Z and Flag_N are registered alongside Shift_Out in stage 2 and held during stalls.
  - Flag_Z = (result == 0).
  - Flag_N = result[DATA_W-1].
  - Flags update for all modes, including pass-through.
- Undefined: the flag registers are not built and Flag_Z = Flag_N = 0 constantly. Ports remain present.

Test Plan:
- Reset, then SLL of 0x0001 by 4, dst 3, Out_Ready=1 -> Out_Valid two cycles later with Shift_Out=0x0010, Out_Dst=3, Flag_Z=0.
- Back-to-back SRA 0x8000>>3, ROR 0x00F1>>4, pass-through 0x1234 -> results 0xF000, 0x100F, 0x1234 on three consecutive cycles; In_Ready stays 1.
- Hold Out_Ready=0 with three ops issued -> two accepted, then In_Ready=0. Shift_Out holds the first result. Releasing Out_Ready drains the results in order with no loss or duplication.
- Flush asserted with two ops in flight and In_Valid=1 -> next cycle Out_Valid=0, and the discarded ops never appear.
- SLL 0x0001 by 15 -> 0x8000 (Flag_N=1 with SHIFT_FLAGS_EN). SLL 0x8000 by 1 -> 0x0000 (Flag_Z=1 with SHIFT_FLAGS_EN). Shift_Val=0 in each mode returns 0xA5A5.
- rst_n pulsed low mid-stall -> Out_Valid drops immediately (async) and all outputs read 0 until a new input transfer.

Source files
------------

// File: rtl/shift_exec_pipe_if.sv
// Handshake and data bundle for shift_exec_pipe: operand side (In_*), result side (Out_*), and flush.
// The master drives operations and accepts results; the slave is the shift pipe.
interface shift_exec_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4,
  parameter int TAG_W   = 4
);
  logic               In_Valid;
  logic               In_Ready;
  logic [DATA_W-1:0]  Shift_In;
  logic [SHAMT_W-1:0] Shift_Val;
  logic [1:0]         Shift_Mode;
  logic [TAG_W-1:0]   In_Dst;
  logic               Flush;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [DATA_W-1:0]  Shift_Out;
  logic [TAG_W-1:0]   Out_Dst;
  logic               Flag_Z;
  logic               Flag_N;

  // A transfer happens on a rising edge where valid and ready are both 1. Valid with
  // its payload is held until that edge; ready may depend combinationally on downstream ready.
  modport master (
    output In_Valid, Shift_In, Shift_Val, Shift_Mode, In_Dst, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Shift_Out, Out_Dst, Flag_Z, Flag_N
  );

  modport slave (
    input  In_Valid, Shift_In, Shift_Val, Shift_Mode, In_Dst, Flush, Out_Ready,
    output In_Ready, Out_Valid, Shift_Out, Out_Dst, Flag_Z, Flag_N
  );
endinterface

// File: rtl/shift_exec_pipe.sv
// Two-stage execute shift unit (SLL / SRA / ROR / pass) with valid/ready on both sides and flush.
// Define SHIFT_FLAGS_EN to build the registered zero/negative result flags.
module shift_exec_pipe #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4,
  parameter int TAG_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_exec_pipe_if.slave bus
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_op;
  logic [SHAMT_W-1:0] s1_amt;
  logic [1:0]         s1_mode;
  logic [TAG_W-1:0]   s1_dst;

  logic               s2_valid;
  logic [DATA_W-1:0]  s2_res;
  logic [TAG_W-1:0]   s2_dst;

  logic s2_adv;
  logic s1_adv;
  logic in_ready;
  logic in_load;
  logic s2_load;

  logic [2*DATA_W-1:0] rot_src;
  logic [2*DATA_W-1:0] rot_shift;
  logic [DATA_W-1:0]   result;

  assign s2_adv   = !s2_valid || bus.Out_Ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  // Flush wins: nothing is captured on a flush edge, so discarded ops never touch the data regs.
  assign in_load = bus.In_Valid && in_ready && !bus.Flush;
  assign s2_load = s1_adv && !bus.Flush;

  // Rotate by shifting a doubled copy; the low half is the rotated word for any amount.
  assign rot_src   = {s1_op, s1_op};
  assign rot_shift = rot_src >> s1_amt;

  always_comb begin
    result = s1_op;
    case (s1_mode)
      MODE_SLL: result = s1_op << s1_amt;
      MODE_SRA: result = $signed(s1_op) >>> s1_amt;
      MODE_ROR: result = rot_shift[DATA_W-1:0];
      default:  result = s1_op;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_op    <= '0;
      s1_amt   <= '0;
      s1_mode  <= '0;
      s1_dst   <= '0;
      s2_res   <= '0;
      s2_dst   <= '0;
    end else begin
      if (bus.Flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv)   s2_valid <= s1_valid;
        if (in_ready) s1_valid <= bus.In_Valid;
      end
      if (in_load) begin
        s1_op   <= bus.Shift_In;
        s1_amt  <= bus.Shift_Val;
        s1_mode <= bus.Shift_Mode;
        s1_dst  <= bus.In_Dst;
      end
      if (s2_load) begin
        s2_res <= result;
        s2_dst <= s1_dst;
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic flag_z;
  logic flag_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (s2_load) begin
      flag_z <= (result == '0);
      flag_n <= result[DATA_W-1];
    end
  end

  assign bus.Flag_Z = flag_z;
  assign bus.Flag_N = flag_n;
`else
  assign bus.Flag_Z = 1'b0;
  assign bus.Flag_N = 1'b0;
`endif

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = s2_valid;
  assign bus.Shift_Out = s2_res;
  assign bus.Out_Dst   = s2_dst;

endmodule
